// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp codes and default phase durations for the
// two-road intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GREEN    = 3'd0,
        A_YELLOW   = 3'd1,
        ALLRED_AB  = 3'd2,
        B_GREEN    = 3'd3,
        B_YELLOW   = 3'd4,
        ALLRED_BA  = 3'd5,
        PED_WALK   = 3'd6,
        PH_ILLEGAL = 3'd7
    } phase_t;

    typedef enum logic [1:0] {
        LIGHT_R = 2'd0,
        LIGHT_Y = 2'd1,
        LIGHT_G = 2'd2
    } light_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_GREEN_MIN = 5;
    localparam int DEF_GREEN_MAX = 20;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 4;

    typedef struct packed {
        light_t road_a;
        light_t road_b;
        logic   walk;
    } lamp_set_t;

    // Anything not explicitly listed (including the illegal code) shows all-red.
    function automatic lamp_set_t phase_lamps(input phase_t ph);
        lamp_set_t ls;
        ls.road_a = LIGHT_R;
        ls.road_b = LIGHT_R;
        ls.walk   = 1'b0;
        case (ph)
            A_GREEN:  ls.road_a = LIGHT_G;
            A_YELLOW: ls.road_a = LIGHT_Y;
            B_GREEN:  ls.road_b = LIGHT_G;
            B_YELLOW: ls.road_b = LIGHT_Y;
            PED_WALK: ls.walk   = 1'b1;
            default:  ls.walk   = 1'b0;
        endcase
        return ls;
    endfunction

    function automatic logic dur_ok(input int d, input int w);
        return (d >= 1) && (d < (1 << w));
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase counter with synchronous clear and optional hold at a limit.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic             sat_en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             at_limit;

    assign at_limit = sat_en && (cnt_reg == limit);

    // Clear is not tick-gated so a forced recovery also restarts the count.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (tick && !at_limit) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer with demand sensing, min/max green,
// all-red clearance and a latched pedestrian walk phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sa,
    input  logic       sb,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic       Ra,
    output logic       Ya,
    output logic       Ga,
    output logic       Rb,
    output logic       Yb,
    output logic       Gb,
    output logic [1:0] light_a,
    output logic [1:0] light_b,
    output logic [2:0] phase
);

    generate
        if (!(GREEN_MIN >= 1 && GREEN_MIN <= GREEN_MAX && GREEN_MAX < (1 << CNT_W))
            || !dur_ok(YELLOW_T, CNT_W) || !dur_ok(ALLRED_T, CNT_W)
            || !dur_ok(WALK_T, CNT_W)) begin : g_bad_params
            $error("traffic_phase_scheduler: illegal duration parameters");
        end
    endgenerate

    localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_C = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_C = CNT_W'(WALK_T - 1);

    phase_t           state_reg;
    phase_t           state_next;
    logic             ped_pend_reg;
    logic             ped_pend_next;
    logic             ped_ack_reg;
    logic             state_change;
    logic             enter_walk;
    logic [CNT_W-1:0] cnt;

    // Only A_GREEN can rest indefinitely, so only it needs the counter held.
    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clr    (state_change),
        .sat_en (state_reg == A_GREEN),
        .limit  (GMAX_C),
        .cnt    (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ALLRED_BA;
            ped_pend_reg <= 1'b0;
            ped_ack_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ped_pend_reg <= ped_pend_next;
            ped_ack_reg  <= enter_walk;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == PH_ILLEGAL) begin
            state_next = ALLRED_BA;
        end else if (tick) begin
            case (state_reg)
                A_GREEN: begin
                    if (cnt >= GMIN_C && (sb || ped_pend_reg))
                        state_next = A_YELLOW;
                end
                A_YELLOW: begin
                    if (cnt == YEL_C)
                        state_next = ALLRED_AB;
                end
                ALLRED_AB: begin
                    if (cnt == ARED_C)
                        state_next = ped_pend_reg ? PED_WALK : B_GREEN;
                end
                B_GREEN: begin
                    if ((cnt >= GMIN_C && (!sb || sa || ped_pend_reg)) || cnt == GMAX_C)
                        state_next = B_YELLOW;
                end
                B_YELLOW: begin
                    if (cnt == YEL_C)
                        state_next = ALLRED_BA;
                end
                ALLRED_BA: begin
                    if (cnt == ARED_C)
                        state_next = A_GREEN;
                end
                PED_WALK: begin
                    if (cnt == WALK_C)
                        state_next = sb ? B_GREEN : A_GREEN;
                end
                default: state_next = ALLRED_BA;
            endcase
        end
    end

    assign state_change = (state_next != state_reg);
    assign enter_walk   = (state_next == PED_WALK) && (state_reg != PED_WALK);

    // Entering the walk phase consumes the request even if ped_req is still high.
    always_comb begin
        ped_pend_next = ped_pend_reg;
        if (enter_walk) begin
            ped_pend_next = 1'b0;
        end else if (ped_req && state_reg != PED_WALK) begin
            ped_pend_next = 1'b1;
        end
    end

    lamp_set_t  lamps;
    logic [1:0] road_code [2];
    logic [1:0] lamp_r;
    logic [1:0] lamp_y;
    logic [1:0] lamp_g;

    always_comb begin
        lamps        = phase_lamps(state_reg);
        road_code[0] = lamps.road_a;
        road_code[1] = lamps.road_b;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_road
            assign lamp_r[gi] = (road_code[gi] == LIGHT_R);
            assign lamp_y[gi] = (road_code[gi] == LIGHT_Y);
            assign lamp_g[gi] = (road_code[gi] == LIGHT_G);
        end
    endgenerate

    assign Ra      = lamp_r[0];
    assign Ya      = lamp_y[0];
    assign Ga      = lamp_g[0];
    assign Rb      = lamp_r[1];
    assign Yb      = lamp_y[1];
    assign Gb      = lamp_g[1];
    assign light_a = road_code[0];
    assign light_b = road_code[1];
    assign walk    = lamps.walk;
    assign ped_ack = ped_ack_reg;
    assign phase   = state_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: phase tables, hand-written corner sequences and a
// randomized run against a tick-level reference model.
module tb_traffic_phase_scheduler;

    localparam int GREEN_MIN = 5;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       sa = 1'b0;
    logic       sb = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       walk;
    logic       Ra, Ya, Ga, Rb, Yb, Gb;
    logic [1:0] light_a;
    logic [1:0] light_b;
    logic [2:0] phase;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .sa      (sa),
        .sb      (sb),
        .ped_req (ped_req),
        .ped_ack (ped_ack),
        .walk    (walk),
        .Ra      (Ra),
        .Ya      (Ya),
        .Ga      (Ga),
        .Rb      (Rb),
        .Yb      (Yb),
        .Gb      (Gb),
        .light_a (light_a),
        .light_b (light_b),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Lamp codes per phase: A_GREEN, A_YELLOW, ALLRED_AB, B_GREEN, B_YELLOW, ALLRED_BA, PED_WALK
    int la_tab [7] = '{2, 1, 0, 0, 0, 0, 0};
    int lb_tab [7] = '{0, 0, 0, 2, 1, 0, 0};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic logic [2:0] lamps3(input int code);
        if (code == 0) return 3'b100;
        if (code == 1) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [13:0] pack_exp(input int ph, input int la, input int lb, input int w);
        logic [2:0] p3;
        logic [1:0] a2;
        logic [1:0] b2;
        p3 = 3'(ph);
        a2 = 2'(la);
        b2 = 2'(lb);
        return {p3, a2, b2, (w != 0), lamps3(la), lamps3(lb)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {phase, light_a, light_b, walk, Ra, Ya, Ga, Rb, Yb, Gb};
    endfunction

    task automatic apply_reset(input logic sa_v, input logic sb_v);
        sa = sa_v; sb = sb_v; ped_req = 1'b0;
        rst = 1'b1; tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_lamps", {2'b0, dut_vec()}, {2'b0, pack_exp(5, 0, 0, 0)});
        check("reset_ack", {15'b0, ped_ack}, 16'h0);
        rst = 1'b0; tick = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        @(posedge clk);
        #1;
        ped_req = 1'b0;
    endtask

    typedef struct {
        bit do_rst;
        bit sa;
        bit sb;
        bit ped;
        int n;
        int ph;
        int la;
        int lb;
        int w;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit a, input bit b, input bit p,
                                input int n, input int ph, input int la, input int lb, input int w);
        vec_t v;
        v.do_rst = r; v.sa = a; v.sb = b; v.ped = p;
        v.n = n; v.ph = ph; v.la = la; v.lb = lb; v.w = w;
        return v;
    endfunction

    // Reference model: phase number plus ticks elapsed in the phase.
    int m_ph;
    int m_el;
    bit m_pend;
    bit m_ack;

    function automatic void model_step(input bit r, input bit t, input bit a, input bit b, input bit p);
        int nph;
        int done;
        if (r) begin
            m_ph = 5; m_el = 0; m_pend = 0; m_ack = 0;
            return;
        end
        nph = m_ph;
        if (t) begin
            done = m_el + 1;
            case (m_ph)
                0: if (done >= GREEN_MIN && (b || m_pend)) nph = 1;
                1: if (done >= YELLOW_T) nph = 2;
                2: if (done >= ALLRED_T) nph = m_pend ? 6 : 3;
                3: if ((done >= GREEN_MIN && (!b || a || m_pend)) || done >= GREEN_MAX) nph = 4;
                4: if (done >= YELLOW_T) nph = 5;
                5: if (done >= ALLRED_T) nph = 0;
                default: if (done >= WALK_T) nph = b ? 3 : 0;
            endcase
            m_el = (nph != m_ph) ? 0 : done;
        end
        m_ack = (nph == 6) && (m_ph != 6);
        if (m_ack) m_pend = 0;
        else if (p && m_ph != 6) m_pend = 1;
        m_ph = nph;
    endfunction

    initial begin
        vec_t tbl[$];
        int   bad;

        // Side demand: 5 green, 2 yellow, 1 all-red, 20 max green B, back to A.
        tbl.push_back(mk(1, 0, 1, 0, 5, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 20, 3, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0));
        // Pedestrian pulse at A tick 2, walk 4 ticks, then main-road rest.
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4, 6, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 60, 0, 2, 0, 0));
        // Early B exit on sb drop (min green honoured), then sa forces exit at cnt 7.
        tbl.push_back(mk(1, 0, 1, 0, 5, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 3, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 3, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8, 3, 0, 2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4, 0, 1, 0));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) apply_reset(tbl[i].sa, tbl[i].sb);
            sa = tbl[i].sa;
            sb = tbl[i].sb;
            if (tbl[i].ped) pulse_ped();
            for (int k = 0; k < tbl[i].n; k++) begin
                do_tick();
                check($sformatf("tbl%0d_tick%0d", i, k), {2'b0, dut_vec()},
                      {2'b0, pack_exp(tbl[i].ph, tbl[i].la, tbl[i].lb, tbl[i].w)});
            end
            $display("tbl %0d: sa=%0d sb=%0d ped=%0d ticks=%0d phase=%0d", i,
                     tbl[i].sa, tbl[i].sb, tbl[i].ped, tbl[i].n, phase);
        end

        // ped_ack timing, request during walk ignored, tick freeze, reset abort.
        apply_reset(1'b0, 1'b0);
        do_tick();
        pulse_ped();
        repeat (8) do_tick();
        check("walk_entered", {13'b0, phase}, 16'd6);
        check("ack_first", {15'b0, ped_ack}, 16'd1);
        do_idle();
        check("ack_drop", {15'b0, ped_ack}, 16'd0);
        pulse_ped();
        repeat (4) do_tick();
        check("walk_done", {2'b0, dut_vec()}, {2'b0, pack_exp(0, 2, 0, 0)});
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            do_tick();
            if (phase != 3'd0 || walk || ped_ack) bad++;
        end
        check("ped_not_relatched", 16'(bad), 16'd0);
        $display("seq ped: walk once, rest in A, phase=%0d", phase);

        sb = 1'b1;
        for (int k = 0; k < 10; k++) if (phase != 3'd3) do_tick();
        check("reach_bgreen", {13'b0, phase}, 16'd3);
        repeat (4) do_tick();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            do_idle();
            if (phase != 3'd3) bad++;
        end
        check("freeze_phase", 16'(bad), 16'd0);
        sb = 1'b0;
        do_tick();
        check("freeze_cnt_kept", {2'b0, dut_vec()}, {2'b0, pack_exp(4, 0, 1, 0)});
        rst = 1'b1;
        do_idle();
        rst = 1'b0;
        check("reset_abort", {2'b0, dut_vec()}, {2'b0, pack_exp(5, 0, 0, 0)});
        $display("seq freeze: phase held 100 clk, reset abort phase=%0d", phase);

        // Randomized run against the reference model.
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, t, p;
            r = (i < 2) || ($urandom_range(0, 1999) == 0);
            t = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) sa = ~sa;
            if ($urandom_range(0, 29) == 0) sb = ~sb;
            rst = r; tick = t; ped_req = p;
            model_step(r, t, sa, sb, p);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", i), {1'b0, ped_ack, dut_vec()},
                  {1'b0, m_ack, pack_exp(m_ph, la_tab[m_ph], lb_tab[m_ph], (m_ph == 6) ? 1 : 0)});
            if (i % 500 == 499) $display("rand block %0d: phase=%0d model=%0d", i / 500, phase, m_ph);
        end
        rst = 1'b0; tick = 1'b0; ped_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
